intensity_accum_pclk: RTL and testbench
=======================================

// Module: intensity_accum_pclk
// PURPOSE
//  Pixel-clock stage that converts each incoming RGB pixel to luma and sums luma over one video frame.
//  At frame end it publishes a stable 32-bit frame sum plus a stretched end-of-frame level.
//  Downstream, the intensity capture stage synchronises that level into its clock domain.
//  It latches the sum on the falling edge of the synchronised level.
//  Sits between the video pipeline tap (SOF/EOF/valid RGB) and the intensity capture stage.
// PARAMETERS
//  PIX_W        8    bits per colour channel
//  SUM_W        32   accumulator / published sum width
//  EOF_STRETCH  8    cycles eof_o is held high; minimum 4
//  XY_W         12   ROI coordinate counter width (used only with ROI feature)
// PORTS
//  clk          in   1        pixel clock
//  resetn       in   1        asynchronous, active-low reset
//  sof_i        in   1        start-of-frame pulse, 1 cycle, precedes first pixel
//  pix_valid_i  in   1        pixel qualifier
//  pix_rgb_i    in   3*PIX_W  {R,G,B}, sampled when pix_valid_i=1
//  eol_i        in   1        end-of-line, coincident with last valid pixel of line
//  eof_i        in   1        end-of-frame, coincident with last valid pixel of frame
//  roi_x0_i/x1_i/y0_i/y1_i  in XY_W  inclusive ROI bounds (ROI feature only)
//  sum_o        out  SUM_W    published frame luma sum
//  eof_o        out  1        stretched frame-done level, to capture stage
//  ovf_o        out  1        sum_o frame saturated
//  frame_err_o  out  1        1-cycle pulse: frame aborted by sof_i before eof_i
// BEHAVIOUR
//  Reset: sum_o=0, eof_o=0, ovf_o=0, frame_err_o=0; accumulator=0; FSM=IDLE.
//  Luma: Y = (77*R + 150*G + 29*B) >> 8, unsigned, range 0..255 for PIX_W=8; one register stage.
//  The valid/eof qualifiers are delayed by the same stage, so the last pixel is always included.
//  FSM IDLE: ignore pixels; sof_i -> ACCUM with accumulator cleared.
//  FSM ACCUM: delayed valid adds Y. Adds saturate at 2^SUM_W-1 and set the sticky internal ovf flag.
//  ACCUM exit on delayed eof: sum_o <= acc + final Y (saturated); ovf_o <= ovf flag;
//    eof_o <= 1; stretch counter loaded; -> IDLE.
//  eof_o: held high exactly EOF_STRETCH cycles, then 0. Stretch runs independent of FSM.
//  sum_o/ovf_o change only on a frame-end commit. They are stable from the eof_o rise until the next commit.
//  sof_i while ACCUM: frame_err_o pulses; accumulator and ovf cleared; stay ACCUM.
//    Nothing is published for the aborted frame.
//  sof_i in same cycle as delayed eof commit: commit first, then start new frame (acc=0).
//  Frame-end commit while eof_o still high: counter reloads, eof_o stays high.
//    No falling edge occurs for the first frame; the downstream stage captures only the latest sum.
//  eof_i without a preceding sof_i (IDLE): ignored, no commit.
//  Reset mid-frame: all state cleared; the next sof_i starts cleanly.
// CONFIGURATION
//  INTENSITY_ROI_EN defined: x/y counters (x resets on eol, y on sof).
//    A pixel is summed only if x0<=x<=x1 and y0<=y<=y1.
//    ROI bounds are sampled on sof_i and held for the frame.
//  INTENSITY_ROI_EN undefined: no counters, no roi_* ports; every valid pixel is summed.
// STRUCTURE
//  Package intensity_pkg: luma coefficients (77/150/29), LUMA_SHIFT=8,
//    FSM enum {IDLE, ACCUM}, SUM_W default.
//  Sub-module rgb_to_luma: registered RGB->Y with valid/eof passthrough.
//  Top level holds the FSM, accumulator, stretch counter and ROI logic.
// TESTING
//  1. 4x2 frame of 0xFFFFFF -> Y=255 each; sum_o=2040; eof_o high 8 cycles; ovf_o=0.
//  2. 4x1 frame R=0x10,G=0x20,B=0x30 -> Y=(1232+4800+1392)>>8=29; sum_o=116.
//  3. sof_i after 3 pixels, then full 2-pixel frame of 0xFFFFFF -> frame_err_o 1 pulse; sum_o=510.
//  4. SUM_W=10, 8 pixels of Y=255 -> sum_o=1023, ovf_o=1; next frame of 1 black pixel -> sum_o=0, ovf_o=0.
//  5. Two 1-pixel frames with commits 3 cycles apart -> eof_o stays high continuously;
//     falls 8 cycles after second commit with the second sum.
//  6. ROI_EN, 4x4 frame all 0xFFFFFF, ROI x1..2 y1..2 -> sum_o=4*255=1020.
//     Reset asserted mid-frame -> all outputs 0.

Source files
------------

// File: rtl/intensity_pkg.sv
// rtl/intensity_pkg.sv - shared constants and types for the frame luma accumulator
package intensity_pkg;

    localparam int unsigned LUMA_R     = 77;
    localparam int unsigned LUMA_G     = 150;
    localparam int unsigned LUMA_B     = 29;
    localparam int unsigned LUMA_SHIFT = 8;
    localparam int          SUM_W_DEF  = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/rgb_to_luma.sv
// rtl/rgb_to_luma.sv - registered RGB to luma conversion with valid/eof passthrough
module rgb_to_luma
    import intensity_pkg::*;
#(
    parameter int PIX_W = 8
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               valid_i,
    input  logic               eof_i,
    input  logic [3*PIX_W-1:0] rgb_i,
    output logic [PIX_W-1:0]   y_o,
    output logic               valid_o,
    output logic               eof_o
);

    // Coefficients sum to 2^LUMA_SHIFT, so the weighted sum fits in PIX_W+LUMA_SHIFT bits.
    localparam int PW = PIX_W + int'(LUMA_SHIFT);

    logic [PW-1:0]    w_r;
    logic [PW-1:0]    w_g;
    logic [PW-1:0]    w_b;
    logic [PW-1:0]    w_sum;
    logic [PIX_W-1:0] w_y;

    logic [PIX_W-1:0] r_y;
    logic             r_valid;
    logic             r_eof;

    assign w_r   = PW'(rgb_i[3*PIX_W-1:2*PIX_W]);
    assign w_g   = PW'(rgb_i[2*PIX_W-1:PIX_W]);
    assign w_b   = PW'(rgb_i[PIX_W-1:0]);
    assign w_sum = (w_r * PW'(LUMA_R)) + (w_g * PW'(LUMA_G)) + (w_b * PW'(LUMA_B));
    assign w_y   = PIX_W'(w_sum >> LUMA_SHIFT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_y     <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_y     <= w_y;
            r_valid <= valid_i;
            r_eof   <= eof_i;
        end
    end

    assign y_o     = r_y;
    assign valid_o = r_valid;
    assign eof_o   = r_eof;

endmodule

// File: rtl/intensity_accum_pclk.sv
// rtl/intensity_accum_pclk.sv - per-frame luma sum with stretched frame-done level; optional ROI via INTENSITY_ROI_EN
module intensity_accum_pclk
    import intensity_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int SUM_W       = SUM_W_DEF,
    parameter int EOF_STRETCH = 8,
    parameter int XY_W        = 12
)(
    input  logic               clk,
    input  logic               resetn,
    input  logic               sof_i,
    input  logic               pix_valid_i,
    input  logic [3*PIX_W-1:0] pix_rgb_i,
    input  logic               eol_i,
    input  logic               eof_i,
`ifdef INTENSITY_ROI_EN
    input  logic [XY_W-1:0]    roi_x0_i,
    input  logic [XY_W-1:0]    roi_x1_i,
    input  logic [XY_W-1:0]    roi_y0_i,
    input  logic [XY_W-1:0]    roi_y1_i,
`endif
    output logic [SUM_W-1:0]   sum_o,
    output logic               eof_o,
    output logic               ovf_o,
    output logic               frame_err_o
);

    localparam int CNT_W = $clog2(EOF_STRETCH + 1);

    logic             w_pix_valid;
    logic [PIX_W-1:0] w_dy;
    logic             w_dvalid;
    logic             w_deof;

`ifdef INTENSITY_ROI_EN
    logic [XY_W-1:0] r_x;
    logic [XY_W-1:0] r_y;
    logic [XY_W-1:0] r_x0;
    logic [XY_W-1:0] r_x1;
    logic [XY_W-1:0] r_y0;
    logic [XY_W-1:0] r_y1;

    // Bounds are frozen at sof_i so the window cannot move mid-frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x  <= '0;
            r_y  <= '0;
            r_x0 <= '0;
            r_x1 <= '0;
            r_y0 <= '0;
            r_y1 <= '0;
        end else if (sof_i) begin
            r_x  <= '0;
            r_y  <= '0;
            r_x0 <= roi_x0_i;
            r_x1 <= roi_x1_i;
            r_y0 <= roi_y0_i;
            r_y1 <= roi_y1_i;
        end else if (pix_valid_i) begin
            if (eol_i) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign w_pix_valid = pix_valid_i && (r_x >= r_x0) && (r_x <= r_x1)
                         && (r_y >= r_y0) && (r_y <= r_y1);
`else
    logic w_unused;

    assign w_unused    = eol_i | (XY_W == 0);
    assign w_pix_valid = pix_valid_i;
`endif

    rgb_to_luma #(
        .PIX_W (PIX_W)
    ) u_luma (
        .clk     (clk),
        .resetn  (resetn),
        .valid_i (w_pix_valid),
        .eof_i   (eof_i),
        .rgb_i   (pix_rgb_i),
        .y_o     (w_dy),
        .valid_o (w_dvalid),
        .eof_o   (w_deof)
    );

    state_t           r_state;
    state_t           w_state_n;
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] w_acc_n;
    logic             r_ovf;
    logic             w_ovf_n;
    logic [SUM_W-1:0] r_sum;
    logic             r_ovf_o;
    logic             r_eof;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_commit;
    logic             w_err;

    logic [SUM_W:0]   w_add;
    logic [SUM_W-1:0] w_acc_y;
    logic             w_ovf_y;

    assign w_add   = {1'b0, r_acc} + (SUM_W + 1)'(w_dy);
    assign w_acc_y = !w_dvalid ? r_acc : (w_add[SUM_W] ? '1 : w_add[SUM_W-1:0]);
    assign w_ovf_y = r_ovf | (w_dvalid & w_add[SUM_W]);

    // A delayed eof and a new sof in the same cycle commit the old frame, then restart.
    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_ovf_n   = r_ovf;
        w_commit  = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_deof) begin
                    w_commit  = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_acc_n = w_acc_y;
                    w_ovf_n = w_ovf_y;
                end
                if (sof_i) begin
                    w_err     = !w_deof;
                    w_acc_n   = '0;
                    w_ovf_n   = 1'b0;
                    w_state_n = ACCUM;
                end
            end
            default: begin
                if (sof_i) begin
                    w_acc_n   = '0;
                    w_ovf_n   = 1'b0;
                    w_state_n = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_sum   <= '0;
            r_ovf_o <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_ovf   <= w_ovf_n;
            r_err   <= w_err;
            if (w_commit) begin
                r_sum   <= w_acc_y;
                r_ovf_o <= w_ovf_y;
            end
        end
    end

    // eof_o is a plain register so the capture domain never sees a decode glitch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_eof <= 1'b0;
            r_cnt <= '0;
        end else if (w_commit) begin
            r_eof <= 1'b1;
            r_cnt <= CNT_W'(EOF_STRETCH - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else begin
            r_eof <= 1'b0;
        end
    end

    assign sum_o       = r_sum;
    assign eof_o       = r_eof;
    assign ovf_o       = r_ovf_o;
    assign frame_err_o = r_err;

endmodule

// File: tb/tb_intensity_accum_pclk.sv
// tb/tb_intensity_accum_pclk.sv - directed self-checking bench for intensity_accum_pclk
module tb_intensity_accum_pclk;

    localparam int PIX_W = 8;
    localparam int XY_W  = 12;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               sof_i = 1'b0;
    logic               pix_valid_i = 1'b0;
    logic [3*PIX_W-1:0] pix_rgb_i = '0;
    logic               eol_i = 1'b0;
    logic               eof_i = 1'b0;
    logic [XY_W-1:0]    roi_x0 = '0;
    logic [XY_W-1:0]    roi_x1 = '1;
    logic [XY_W-1:0]    roi_y0 = '0;
    logic [XY_W-1:0]    roi_y1 = '1;

    logic [31:0] sum32;
    logic        eof32, ovf32, err32;
    logic [9:0]  sum10;
    logic        eof10, ovf10, err10;

    int n_vec = 0;
    int n_err = 0;
    int len;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] MIX   = 24'h102030;
    localparam logic [23:0] BLACK = 24'h000000;

    always #5 clk = ~clk;

    intensity_accum_pclk #(.PIX_W(PIX_W), .SUM_W(32), .EOF_STRETCH(8), .XY_W(XY_W)) u_dut32 (
        .clk(clk), .resetn(resetn), .sof_i(sof_i), .pix_valid_i(pix_valid_i),
        .pix_rgb_i(pix_rgb_i), .eol_i(eol_i), .eof_i(eof_i),
`ifdef INTENSITY_ROI_EN
        .roi_x0_i(roi_x0), .roi_x1_i(roi_x1), .roi_y0_i(roi_y0), .roi_y1_i(roi_y1),
`endif
        .sum_o(sum32), .eof_o(eof32), .ovf_o(ovf32), .frame_err_o(err32)
    );

    intensity_accum_pclk #(.PIX_W(PIX_W), .SUM_W(10), .EOF_STRETCH(8), .XY_W(XY_W)) u_dut10 (
        .clk(clk), .resetn(resetn), .sof_i(sof_i), .pix_valid_i(pix_valid_i),
        .pix_rgb_i(pix_rgb_i), .eol_i(eol_i), .eof_i(eof_i),
`ifdef INTENSITY_ROI_EN
        .roi_x0_i(roi_x0), .roi_x1_i(roi_x1), .roi_y0_i(roi_y0), .roi_y1_i(roi_y1),
`endif
        .sum_o(sum10), .eof_o(eof10), .ovf_o(ovf10), .frame_err_o(err10)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sof_cyc();
        sof_i = 1'b1;
        tick();
        sof_i = 1'b0;
    endtask

    task automatic pix(input logic [23:0] rgb, input logic eol, input logic eof);
        pix_valid_i = 1'b1;
        pix_rgb_i   = rgb;
        eol_i       = eol;
        eof_i       = eof;
        tick();
        pix_valid_i = 1'b0;
        pix_rgb_i   = '0;
        eol_i       = 1'b0;
        eof_i       = 1'b0;
    endtask

    task automatic eof_high_len(output int n);
        n = 0;
        while (eof32 && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_sum32", sum32, 0);
        check("rst_eof32", eof32, 0);
        check("rst_ovf32", ovf32, 0);
        check("rst_err32", err32, 0);
        check("rst_sum10", sum10, 0);
        resetn = 1'b1;
        tick();

        // 4x2 white frame
        sof_cyc();
        for (int i = 0; i < 8; i++) pix(WHITE, (i % 4) == 3, i == 7);
        tick();
        check("t1_sum32", sum32, 2040);
        check("t1_eof32", eof32, 1);
        check("t1_ovf32", ovf32, 0);
        check("t1_sum10_sat", sum10, 1023);
        check("t1_ovf10", ovf10, 1);
        eof_high_len(len);
        check("t1_eof_len", len, 8);

        // 4x1 mixed-colour frame, Y=29 per pixel
        sof_cyc();
        for (int i = 0; i < 4; i++) pix(MIX, i == 3, i == 3);
        tick();
        check("t2_sum32", sum32, 116);
        check("t2_ovf32", ovf32, 0);
        check("t2_sum10", sum10, 116);
        check("t2_ovf10", ovf10, 0);

        // aborted frame then a good 2-pixel frame
        sof_cyc();
        for (int i = 0; i < 3; i++) pix(WHITE, 1'b0, 1'b0);
        sof_i = 1'b1;
        tick();
        sof_i = 1'b0;
        check("t3_err_pulse", err32, 1);
        check("t3_sum_held", sum32, 116);
        tick();
        check("t3_err_clear", err32, 0);
        pix(WHITE, 1'b0, 1'b0);
        pix(WHITE, 1'b1, 1'b1);
        tick();
        check("t3_sum32", sum32, 510);
        check("t3_sum10", sum10, 510);

        // saturation on the narrow instance, then a black frame clears it
        sof_cyc();
        for (int i = 0; i < 8; i++) pix(WHITE, i == 7, i == 7);
        tick();
        check("t4_sum10_sat", sum10, 1023);
        check("t4_ovf10_set", ovf10, 1);
        sof_cyc();
        pix(BLACK, 1'b1, 1'b1);
        tick();
        check("t4_sum10_zero", sum10, 0);
        check("t4_ovf10_clr", ovf10, 0);
        check("t4_sum32_zero", sum32, 0);

        // wait out the stretch, then two commits three cycles apart
        len = 0;
        while (eof32 && len < 20) begin
            len++;
            tick();
        end
        check("t5_eof_idle", eof32, 0);
        sof_cyc();
        pix(WHITE, 1'b1, 1'b1);
        tick();
        check("t5_sumA", sum32, 255);
        sof_cyc();
        check("t5_eof_hold1", eof32, 1);
        pix(MIX, 1'b1, 1'b1);
        check("t5_eof_hold2", eof32, 1);
        check("t5_sumA_held", sum32, 255);
        tick();
        check("t5_sumB", sum32, 29);
        eof_high_len(len);
        check("t5_eof_len", len, 8);

        // eof without sof is ignored
        pix(WHITE, 1'b1, 1'b1);
        tick();
        tick();
        check("idle_eof_sum", sum32, 29);
        check("idle_eof_lvl", eof32, 0);

        // sof coincident with the delayed eof commit
        sof_cyc();
        pix(WHITE, 1'b1, 1'b1);
        sof_i = 1'b1;
        tick();
        sof_i = 1'b0;
        check("b2b_sum1", sum32, 255);
        check("b2b_no_err", err32, 0);
        pix(MIX, 1'b1, 1'b1);
        tick();
        check("b2b_sum2", sum32, 29);

        // reset in the middle of a frame
        sof_cyc();
        for (int i = 0; i < 5; i++) pix(WHITE, i == 4, i == 4);
        tick();
        check("t6_sum32", sum32, 1275);
        check("t6_ovf10", ovf10, 1);
        sof_cyc();
        pix(WHITE, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        check("t6_rst_sum32", sum32, 0);
        check("t6_rst_eof32", eof32, 0);
        check("t6_rst_ovf10", ovf10, 0);
        check("t6_rst_sum10", sum10, 0);
        check("t6_rst_err32", err32, 0);
        tick();
        resetn = 1'b1;
        tick();
        sof_cyc();
        pix(MIX, 1'b0, 1'b0);
        pix(MIX, 1'b1, 1'b1);
        tick();
        check("t6_clean_sum32", sum32, 58);
        check("t6_clean_ovf10", ovf10, 0);

`ifdef INTENSITY_ROI_EN
        roi_x0 = 12'd1;
        roi_x1 = 12'd2;
        roi_y0 = 12'd1;
        roi_y1 = 12'd2;
        sof_cyc();
        for (int i = 0; i < 16; i++) pix(WHITE, (i % 4) == 3, i == 15);
        tick();
        check("roi_sum32", sum32, 1020);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
